// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared select encodings and the per-stage destination tag used by the forwarding unit.
package fwd_pkg;

    localparam int TAG_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_POST  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } stage_tag_t;

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// ID-stage instruction fields in, stall and EX operand-mux selects out.
interface fwd_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_ctrl_unit_sel_prio.sv
// Combinational youngest-first match of one source register against the EX/MEM/WB tags.
// Zero latency; also flags a load in EX that this source depends on.
module fwd_sel_prio
    import fwd_pkg::*;
#(
    parameter int REG_AW = TAG_AW
) (
    input  logic              use_src,
    input  logic [REG_AW-1:0] src,
    input  stage_tag_t        ex_tag,
    input  stage_tag_t        mem_tag,
    input  stage_tag_t        wb_tag,
    output logic [1:0]        sel,
    output logic              ld_hit
);
    logic src_nz;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // x0 is hardwired, so a write to it must never be forwarded.
    assign src_nz  = |src;
    assign hit_ex  = ex_tag.valid  & ex_tag.reg_write  & (ex_tag.rd  == src) & src_nz;
    assign hit_mem = mem_tag.valid & mem_tag.reg_write & (mem_tag.rd == src) & src_nz;
    assign hit_wb  = wb_tag.valid  & wb_tag.reg_write  & (wb_tag.rd  == src) & src_nz;

    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (hit_ex) begin
                sel = FWD_EXMEM;
            end else if (hit_mem) begin
                sel = FWD_MEMWB;
            end else if (hit_wb) begin
                sel = FWD_POST;
            end
        end
    end

    assign ld_hit = use_src & hit_ex & ex_tag.mem_read;

    logic unused_mem_read;
    assign unused_mem_read = mem_tag.mem_read ^ wb_tag.mem_read;

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding/hazard unit: tracks rd tags through EX/MEM/WB/POST, registers operand selects
// for the instruction entering EX (valid its first EX cycle); combinational one-cycle load-use stall.
module fwd_ctrl_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = TAG_AW,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    fwd_ctrl_unit_if.slave bus
);
    stage_tag_t       ex_tag;
    stage_tag_t       mem_tag;
    stage_tag_t       wb_tag;
    stage_tag_t       post_tag;
    stage_tag_t       id_entry;
    logic [1:0]       a_sel_nxt;
    logic [1:0]       b_sel_nxt;
    logic [1:0]       a_sel_q;
    logic [1:0]       b_sel_q;
    logic             a_ld_hit;
    logic             b_ld_hit;
    logic             stall_w;
    logic             id_live;
    logic [CNT_W-1:0] stall_cnt_q;

    fwd_sel_prio #(.REG_AW(REG_AW)) u_prio_a (
        .use_src (bus.id_use_rs1),
        .src     (bus.id_rs1),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (a_sel_nxt),
        .ld_hit  (a_ld_hit)
    );

    fwd_sel_prio #(.REG_AW(REG_AW)) u_prio_b (
        .use_src (bus.id_use_rs2),
        .src     (bus.id_rs2),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (b_sel_nxt),
        .ld_hit  (b_ld_hit)
    );

    // Flush outranks the load-use stall: a killed instruction has no hazard.
    assign stall_w = bus.id_valid & ~bus.flush & (a_ld_hit | b_ld_hit);
    assign id_live = bus.id_valid & ~bus.flush & ~stall_w;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = id_live;
        id_entry.rd        = bus.id_rd;
        id_entry.reg_write = bus.id_reg_write;
        id_entry.mem_read  = bus.id_mem_read;
    end

    // Older stages always advance; a stall only turns the EX slot into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag   <= '0;
            mem_tag  <= '0;
            wb_tag   <= '0;
            post_tag <= '0;
            a_sel_q  <= FWD_RF;
            b_sel_q  <= FWD_RF;
        end else begin
            post_tag <= wb_tag;
            wb_tag   <= mem_tag;
            mem_tag  <= ex_tag;
            ex_tag   <= id_entry;
            if (id_live) begin
                a_sel_q <= a_sel_nxt;
                b_sel_q <= b_sel_nxt;
            end else begin
                a_sel_q <= FWD_RF;
                b_sel_q <= FWD_RF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // The POST tag mirrors the write-back register beside the datapath; no select reads it.
    logic unused_post;
    assign unused_post = ^post_tag;

    assign bus.stall     = stall_w;
    assign bus.fwd_a_sel = a_sel_q;
    assign bus.fwd_b_sel = b_sel_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed and randomized checks of fwd_ctrl_unit against a history-based reference model.
module tb_fwd_ctrl_unit;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fwd_ctrl_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    fwd_ctrl_unit #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ins_t;

    ins_t hist[$];   // hist[0] = instruction currently in EX, hist[1] = MEM, ...
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        ins_t e;
        e.v = 0; e.rd = 0; e.rw = 0; e.ld = 0;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(e);
        exp_cnt = 0;
    endfunction

    // Distance (1..3) to the youngest older producer of r, 0 = register file.
    function automatic logic [1:0] exp_sel(input bit use_s, input int r);
        if (!use_s || r == 0) return 2'b00;
        for (int d = 0; d < 3; d++)
            if (hist[d].v && hist[d].rw && hist[d].rd == r) return 2'(d + 1);
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0;
        bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.flush = 0;
    endtask

    // Called at posedge+1; presents one ID instruction for one clock.
    task automatic issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit ld, input bit fl, output bit stalled);
        logic [1:0] ea, eb;
        bit         live;
        ins_t       e;
        bus.id_valid = v; bus.id_rs1 = rs1[AW-1:0]; bus.id_use_rs1 = u1;
        bus.id_rs2 = rs2[AW-1:0]; bus.id_use_rs2 = u2; bus.id_rd = rd[AW-1:0];
        bus.id_reg_write = rw; bus.id_mem_read = ld; bus.flush = fl;
        #1;
        stalled = v && !fl && hist[0].v && hist[0].ld && hist[0].rw && hist[0].rd != 0 &&
                  ((u1 && hist[0].rd == rs1) || (u2 && hist[0].rd == rs2));
        chk("stall", bus.stall, stalled);
        live = v && !fl && !stalled;
        ea = live ? exp_sel(u1, rs1) : 2'b00;
        eb = live ? exp_sel(u2, rs2) : 2'b00;
        e.v = live; e.rd = rd; e.rw = rw; e.ld = ld;
        @(posedge clk);
        #1;
        hist.push_front(e);
        void'(hist.pop_back());
        if (stalled && exp_cnt < (1 << CW) - 1) exp_cnt++;
        chk("stall_cnt", bus.stall_cnt, exp_cnt);
        if (live || (v && (fl || stalled))) begin
            chk("fwd_a_sel", bus.fwd_a_sel, ea);
            chk("fwd_b_sel", bus.fwd_b_sel, eb);
        end
    endtask

    // Re-presents a stalled instruction, as the held IF/ID register would.
    task automatic run(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit fl, output int nst);
        bit s;
        nst = 0;
        for (int k = 0; k < 3; k++) begin
            issue(v, rs1, u1, rs2, u2, rd, rw, ld, fl, s);
            if (!s) break;
            nst++;
        end
    endtask

    task automatic nops(input int n);
        int ns;
        for (int i = 0; i < n; i++) run(1, 0, 0, 0, 0, 0, 0, 0, 0, ns);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a", bus.fwd_a_sel, 2'b00);
        chk("rst_b", bus.fwd_b_sel, 2'b00);
        chk("rst_cnt", bus.stall_cnt, 0);
        chk("rst_stall", bus.stall, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ns, r1, r2, rdv;
        bit s;
        do_reset();

        // add x5 ; add x6,x5,x1
        run(1, 1, 1, 2, 1, 5, 1, 0, 0, ns);
        run(1, 5, 1, 1, 1, 6, 1, 0, 0, ns);
        chk("raw1_a", bus.fwd_a_sel, 2'b01);
        chk("raw1_b", bus.fwd_b_sel, 2'b00);
        nops(3);

        // lw x7 ; sub x8,x1,x7
        run(1, 2, 1, 0, 0, 7, 1, 1, 0, ns);
        issue(1, 1, 1, 7, 1, 8, 1, 0, 0, s);
        chk("lu_bubble_b", bus.fwd_b_sel, 2'b00);
        issue(1, 1, 1, 7, 1, 8, 1, 0, 0, s);
        chk("lu_b", bus.fwd_b_sel, 2'b10);
        chk("lu_cnt", bus.stall_cnt, 1);
        nops(3);

        // x3 producers at distance 1, 2, 3, then two producers
        run(1, 0, 0, 0, 0, 3, 1, 0, 0, ns);
        run(1, 3, 1, 0, 0, 11, 1, 0, 0, ns);
        chk("dist1", bus.fwd_a_sel, 2'b01);
        nops(3);
        run(1, 0, 0, 0, 0, 3, 1, 0, 0, ns);
        nops(1);
        run(1, 0, 0, 3, 1, 11, 1, 0, 0, ns);
        chk("dist2", bus.fwd_b_sel, 2'b10);
        nops(3);
        run(1, 0, 0, 0, 0, 3, 1, 0, 0, ns);
        nops(2);
        run(1, 3, 1, 3, 1, 11, 1, 0, 0, ns);
        chk("dist3_a", bus.fwd_a_sel, 2'b11);
        chk("dist3_b", bus.fwd_b_sel, 2'b11);
        nops(3);
        run(1, 0, 0, 0, 0, 3, 1, 0, 0, ns);
        run(1, 0, 0, 0, 0, 3, 1, 0, 0, ns);
        run(1, 3, 1, 0, 0, 11, 1, 0, 0, ns);
        chk("youngest", bus.fwd_a_sel, 2'b01);
        nops(3);

        // addi x0,x0,1 ; add x9,x0,x0
        run(1, 0, 1, 0, 0, 0, 1, 0, 0, ns);
        run(1, 0, 1, 0, 1, 9, 1, 0, 0, ns);
        chk("x0_a", bus.fwd_a_sel, 2'b00);
        chk("x0_b", bus.fwd_b_sel, 2'b00);
        nops(3);

        // lw x4 ; dependent flushed
        run(1, 0, 0, 0, 0, 4, 1, 1, 0, ns);
        issue(1, 4, 1, 4, 1, 12, 1, 0, 1, s);
        chk("flush_a", bus.fwd_a_sel, 2'b00);
        chk("flush_b", bus.fwd_b_sel, 2'b00);

        // lw x4 ; dependent, reset asserted between edges
        run(1, 0, 0, 0, 0, 4, 1, 1, 0, ns);
        bus.id_valid = 1; bus.id_rs1 = 5'd4; bus.id_use_rs1 = 1; bus.flush = 0;
        #1;
        chk("pre_rst_stall", bus.stall, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_a", bus.fwd_a_sel, 2'b00);
        chk("mid_rst_cnt", bus.stall_cnt, 0);
        chk("mid_rst_stall", bus.stall, 1'b0);
        do_reset();
        run(1, 4, 1, 4, 1, 10, 1, 0, 0, ns);
        chk("post_rst_a", bus.fwd_a_sel, 2'b00);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            r1  = $urandom_range(0, 7);
            r2  = $urandom_range(0, 7);
            rdv = $urandom_range(0, 7);
            run($urandom_range(0, 7) != 0, r1, 1'($urandom_range(0, 1)), r2,
                1'($urandom_range(0, 1)), rdv, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0), ns);
        end

        // back-to-back dependent loads: 2^CW + 5 stall events
        do_reset();
        run(1, 0, 0, 0, 0, 1, 1, 1, 0, ns);
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            if (i % 2 == 0) run(1, 1, 1, 0, 0, 2, 1, 1, 0, ns);
            else            run(1, 2, 1, 0, 0, 1, 1, 1, 0, ns);
        end
        chk("sat_cnt", bus.stall_cnt, (1 << CW) - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fwd_ctrl_unit.md
Name: fwd_ctrl_unit

Overview:
- Drives the 2-bit `control` selects of the two EX-stage operand 4:1 muxes (rs1 path `fwd_a_sel`, rs2 path `fwd_b_sel`).
- Tracks destination-register tags of in-flight instructions through internal EX/MEM/WB/POST tag registers.
- Compares each decoding instruction's sources against those tags, registers the select so it is valid while that instruction is in EX, and raises a one-cycle load-use stall when forwarding cannot cover the hazard.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_AW  source 1 address.
- id_rs2  in  REG_AW  source 2 address.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination address.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  kill the instruction leaving ID this cycle.
- stall  out  1  hold PC and IF/ID; combinational.
- fwd_a_sel  out  2  rs1 mux select for instruction now in EX.
- fwd_b_sel  out  2  rs2 mux select for instruction now in EX.
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- Select encoding (shared constants):
  - 00 = register-file read.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back data.
  - 11 = POST register (write-back value one cycle after WB; covers a register file without internal bypass).
- Tag register per stage EX, MEM, WB, POST holds {valid, rd, reg_write, mem_read}. Every clk with no stall: POST<=WB, WB<=MEM, MEM<=EX, EX<=ID entry.
- ID entry valid = id_valid & ~flush & ~stall.
- hit(S, r): S.valid & S.reg_write & S.rd==r & r!=0.
- Next select for rs1 (same rule for rs2), evaluated on current tags, youngest match wins:
  - if ~id_use_rs1: 00;
  - else if hit(EX, rs1): 01;
  - else if hit(MEM, rs1): 10;
  - else if hit(WB, rs1): 11;
  - else 00.
- fwd_*_sel registered: they update on the edge on which the ID entry moves into EX.
- Latency: select is valid the first cycle the instruction occupies EX, and constant for that cycle.
- Load-use: stall = id_valid & ~flush & EX.valid & EX.mem_read & ((id_use_rs1 & hit(EX, id_rs1)) | (id_use_rs2 & hit(EX, id_rs2))).
- On a stall edge:
  - EX gets a bubble (valid=0) and fwd_*_sel <= 00.
  - MEM, WB and POST still advance.
  - ID is held by the external pipeline; inputs are re-presented.
- The next cycle the load is in MEM, stall deasserts, and the selects resolve to 10. A stall therefore never exceeds one cycle per hazard.
- Flush has priority over stall. Flush inserts a bubble into EX with selects 00, and stall is 0 that cycle.
- rd==0 never matches, so x0 is never forwarded even with reg_write set.
- If both EX and MEM match, EX wins (01).
- rs1==rs2 produces identical selects on both outputs.
- stall_cnt increments on every clk where stall=1 and holds at all-ones.
- Reset (async, rst_n=0), effective immediately regardless of clk:
  - all tag valid bits 0;
  - fwd_a_sel = fwd_b_sel = 00;
  - stall_cnt = 0;
  - stall = 0 (all tags invalid).
- Reset mid-operation discards all in-flight tags. The first instruction after reset always gets 00.

Decomposition:
- Package fwd_pkg:
  - select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_POST=2'b11;
  - typedef struct stage_tag_t {valid, rd, reg_write, mem_read}.
- One natural sub-module, fwd_sel_prio: combinational priority compare of one source address against the EX/MEM/WB tags, instantiated twice (rs1, rs2).
- Tag shift chain and stall counter stay in the top module.

Test Plan:
- Reset then `add x5` followed by `add x6,x5,x1`: the second instruction's fwd_a_sel=01 in its EX cycle, fwd_b_sel=00, stall=0.
- `lw x7`, then `sub x8,x1,x7`:
  - stall=1 for exactly one cycle;
  - fwd_b_sel=00 during the bubble, then 10 in the sub's EX cycle;
  - stall_cnt=1.
- Writers of x3 at distances 1, 2 and 3 in turn before a reader of x3 → selects 01, 10, 11 respectively. The same writer at distance 1 and 2 → 01 (youngest wins).
- `addi x0,x0,1` then `add x9,x0,x0` → both selects 00, stall=0.
- `lw x4`, then a dependent instruction with flush=1 the same cycle → stall=0 and an EX bubble with selects 00. Assert rst_n low mid-sequence → selects 00, stall_cnt=0 without a clk edge.
- Hold a back-to-back load-use pattern for 2^CNT_W+5 stall events (CNT_W overridden to 4) → stall_cnt saturates at 15.
